// File: rtl/axis_seq_checker.sv
// In-line AXI4-Stream sequence monitor: 2-entry skid buffer plus 0..N-1 sequence checker.
// Optional first-error capture of err_exp/err_got enabled by AXIS_SEQ_CHECKER_FIRST_ERR_EN.
module axis_seq_checker #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [31:0]         packet_size,
    input  logic                err_clear,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [CNT_W-1:0]    pkt_count,
    output logic [CNT_W-1:0]    word_count,
    output logic [CNT_W-1:0]    err_count,
    output logic [3:0]          err_flags,
    output logic [31:0]         err_exp,
    output logic [31:0]         err_got
);
    localparam int unsigned KEEP_W = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StInPkt, StOverrun} state_e;

    logic [DATA_W-1:0] buf_data_q [2];
    logic [KEEP_W-1:0] buf_keep_q [2];
    logic              buf_last_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q, cnt_d;
    logic              s_ready_q;
    logic              push, pop;

    assign push          = s_axis_tvalid && s_ready_q;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign m_axis_tdata  = buf_data_q[rd_ptr_q];
    assign m_axis_tkeep  = buf_keep_q[rd_ptr_q];
    assign m_axis_tlast  = buf_last_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Ready is registered from post-transfer occupancy, so a push never lands on a full buffer.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            s_ready_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_keep_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
            end
        end else begin
            cnt_q     <= cnt_d;
            s_ready_q <= (cnt_d < 2'd2);
            if (push) begin
                buf_data_q[wr_ptr_q] <= s_axis_tdata;
                buf_keep_q[wr_ptr_q] <= s_axis_tkeep;
                buf_last_q[wr_ptr_q] <= s_axis_tlast;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    state_e      state_q, state_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] sz_q, sz_d;
    logic [31:0] sz_in, cur_idx, cur_sz, data32;
    logic [3:0]  beat_flags;
    logic        beat_err;

    assign sz_in  = (packet_size == 32'd0) ? 32'd1 : packet_size;
    assign data32 = 32'(s_axis_tdata);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sz_d       = sz_q;
        beat_flags = 4'b0000;
        cur_idx    = (state_q == StIdle) ? 32'd0 : idx_q;
        cur_sz     = (state_q == StIdle) ? sz_in : sz_q;
        if (push) begin
            beat_flags[3] = (s_axis_tkeep != {KEEP_W{1'b1}});
            if (state_q == StOverrun) begin
                if (s_axis_tlast) begin
                    state_d = StIdle;
                end
            end else begin
                sz_d          = cur_sz;
                beat_flags[0] = (data32 != cur_idx);
                if (s_axis_tlast) begin
                    beat_flags[1] = (cur_idx < cur_sz - 32'd1);
                    state_d       = StIdle;
                end else if (cur_idx == cur_sz - 32'd1) begin
                    beat_flags[2] = 1'b1;
                    state_d       = StOverrun;
                    idx_d         = cur_idx;
                end else begin
                    state_d = StInPkt;
                    idx_d   = cur_idx + 32'd1;
                end
            end
        end
        beat_err = |beat_flags;
    end

    logic [CNT_W-1:0] pkt_count_q, word_count_q, err_count_q;
    logic [3:0]       err_flags_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= StIdle;
            idx_q        <= 32'd0;
            sz_q         <= 32'd1;
            pkt_count_q  <= '0;
            word_count_q <= '0;
            err_count_q  <= '0;
            err_flags_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sz_q    <= sz_d;
            if (push && word_count_q != {CNT_W{1'b1}}) begin
                word_count_q <= word_count_q + 1'b1;
            end
            if (push && s_axis_tlast && pkt_count_q != {CNT_W{1'b1}}) begin
                pkt_count_q <= pkt_count_q + 1'b1;
            end
            // A same-cycle error beat survives the clear.
            if (err_clear) begin
                err_count_q <= beat_err ? CNT_W'(1) : '0;
                err_flags_q <= beat_flags;
            end else begin
                err_flags_q <= err_flags_q | beat_flags;
                if (beat_err && err_count_q != {CNT_W{1'b1}}) begin
                    err_count_q <= err_count_q + 1'b1;
                end
            end
        end
    end

    assign pkt_count  = pkt_count_q;
    assign word_count = word_count_q;
    assign err_count  = err_count_q;
    assign err_flags  = err_flags_q;

`ifdef AXIS_SEQ_CHECKER_FIRST_ERR_EN
    logic        captured_q;
    logic [31:0] err_exp_q, err_got_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            captured_q <= 1'b0;
            err_exp_q  <= 32'd0;
            err_got_q  <= 32'd0;
        end else if (err_clear) begin
            captured_q <= beat_err;
            err_exp_q  <= beat_err ? cur_idx : 32'd0;
            err_got_q  <= beat_err ? data32 : 32'd0;
        end else if (beat_err && !captured_q) begin
            captured_q <= 1'b1;
            err_exp_q  <= cur_idx;
            err_got_q  <= data32;
        end
    end

    assign err_exp = err_exp_q;
    assign err_got = err_got_q;
`else
    assign err_exp = 32'd0;
    assign err_got = 32'd0;
`endif

endmodule

// File: tb/tb_axis_seq_checker.sv
// Directed bench for axis_seq_checker: vector table plus hand-written stall and reset sequences.
module tb_axis_seq_checker;
`ifdef AXIS_SEQ_CHECKER_FIRST_ERR_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] packet_size;
    logic        err_clear;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] pkt_count, word_count, err_count;
    logic [3:0]  err_flags;
    logic [31:0] err_exp, err_got;

    axis_seq_checker #(.DATA_W(32), .CNT_W(32)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .packet_size   (packet_size),
        .err_clear     (err_clear),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pkt_count     (pkt_count),
        .word_count    (word_count),
        .err_count     (err_count),
        .err_flags     (err_flags),
        .err_exp       (err_exp),
        .err_got       (err_got)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] psize;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        clr;
        logic [3:0]  flags;
        logic [31:0] errs;
        logic [31:0] eexp;
        logic [31:0] egot;
    } vec_t;

    vec_t        tbl[$];
    logic [36:0] sb[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic void add(input logic [31:0] psize, input logic [31:0] data,
                                input logic [3:0] keep, input logic last, input logic clr,
                                input logic [3:0] flags, input logic [31:0] errs,
                                input logic [31:0] eexp, input logic [31:0] egot);
        vec_t v;
        v.psize = psize; v.data = data; v.keep = keep; v.last = last; v.clr = clr;
        v.flags = flags; v.errs = errs;
        v.eexp  = CAP_EN ? eexp : 32'd0;
        v.egot  = CAP_EN ? egot : 32'd0;
        tbl.push_back(v);
    endfunction

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                        input logic c);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: tdata 0x%0h not accepted, required within 50 cycles", d);
        end else begin
            err_clear = c;
            tick();
            err_clear = 1'b0;
            sb.push_back({l, k, d});
        end
        s_axis_tvalid = 1'b0;
    endtask

    // Output scoreboard and stall-stability monitor, sampled on the falling edge.
    initial begin
        logic        stall;
        logic [37:0] prev;
        logic [36:0] e;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge aclk);
            if (areset === 1'b1) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
                        prev);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL out_extra: got beat 0x%0h, expected no beat", m_axis_tdata);
                    end else begin
                        e = sb.pop_front();
                        chk("out_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, e);
                    end
                end
                stall = m_axis_tvalid && !m_axis_tready;
                prev  = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk_counts(input string tag, input logic [31:0] p, input logic [31:0] w,
                              input logic [31:0] e, input logic [3:0] f);
        chk({tag, "_pkt"}, pkt_count, p);
        chk({tag, "_word"}, word_count, w);
        chk({tag, "_errs"}, err_count, e);
        chk({tag, "_flags"}, err_flags, f);
    endtask

    initial begin
        areset = 1'b1; packet_size = 32'd4; err_clear = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;

        // Packet size 4, three clean packets.
        for (int p = 0; p < 3; p++)
            for (int w = 0; w < 4; w++) add(4, w, 4'hF, w == 3, 0, 4'b0000, 0, 0, 0);
        // Packet size 1, five single-beat packets.
        for (int p = 0; p < 5; p++) add(1, 0, 4'hF, 1, 0, 4'b0000, 0, 0, 0);
        // Word 2 corrupted, then a clean packet.
        add(4, 0, 4'hF, 0, 0, 4'b0000, 0, 0, 0);
        add(4, 1, 4'hF, 0, 0, 4'b0000, 0, 0, 0);
        add(4, 32'h55, 4'hF, 0, 0, 4'b0001, 1, 2, 32'h55);
        add(4, 3, 4'hF, 1, 0, 4'b0001, 1, 2, 32'h55);
        for (int w = 0; w < 4; w++) add(4, w, 4'hF, w == 3, 0, 4'b0001, 1, 2, 32'h55);
        // Early tlast on word 1, then tlast missing until word 5.
        add(4, 0, 4'hF, 0, 1, 4'b0000, 0, 0, 0);
        add(4, 1, 4'hF, 1, 0, 4'b0010, 1, 1, 1);
        add(4, 0, 4'hF, 0, 0, 4'b0010, 1, 1, 1);
        add(4, 1, 4'hF, 0, 0, 4'b0010, 1, 1, 1);
        add(4, 2, 4'hF, 0, 0, 4'b0010, 1, 1, 1);
        add(4, 3, 4'hF, 0, 0, 4'b0110, 2, 1, 1);
        add(4, 4, 4'hF, 0, 0, 4'b0110, 2, 1, 1);
        add(4, 5, 4'hF, 1, 0, 4'b0110, 2, 1, 1);
        // Back in IDLE: a clean packet adds no error.
        for (int w = 0; w < 4; w++) add(4, w, 4'hF, w == 3, 0, 4'b0110, 2, 1, 1);
        // tkeep error with a clear, then one beat carrying three error kinds.
        add(4, 0, 4'h7, 0, 1, 4'b1000, 1, 0, 0);
        add(4, 9, 4'h3, 1, 0, 4'b1011, 2, 0, 0);

        repeat (2) tick();
        chk("rst_s_ready", s_axis_tready, 0);
        chk("rst_m_valid", m_axis_tvalid, 0);
        chk_counts("rst", 0, 0, 0, 4'b0000);
        chk("rst_err_exp", err_exp, 0);
        chk("rst_err_got", err_got, 0);
        areset = 1'b0;
        tick();
        chk("post_rst_s_ready", s_axis_tready, 1);

        foreach (tbl[i]) begin
            packet_size = tbl[i].psize;
            send(tbl[i].data, tbl[i].keep, tbl[i].last, tbl[i].clr);
            if (i == 0) begin
                chk("latency_valid", m_axis_tvalid, 1);
                chk("latency_data", m_axis_tdata, 0);
            end
            chk($sformatf("v%0d_flags", i), err_flags, tbl[i].flags);
            chk($sformatf("v%0d_errs", i), err_count, tbl[i].errs);
            chk($sformatf("v%0d_err_exp", i), err_exp, tbl[i].eexp);
            chk($sformatf("v%0d_err_got", i), err_got, tbl[i].egot);
        end
        tick();
        chk_counts("table", 14, 39, 2, 4'b1011);

        // Ready toggling 1010..., then a 5-cycle stall with two beats held.
        packet_size = 32'd8;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    m_axis_tready = (i % 2 == 0);
                    tick();
                end
            end
            begin
                for (int b = 0; b < 4; b++) send(b, 4'hF, 0, 0);
            end
        join
        m_axis_tready = 1'b1;
        repeat (3) tick();
        chk("drained_valid", m_axis_tvalid, 0);
        m_axis_tready = 1'b0;
        send(4, 4'hF, 0, 0);
        chk("one_held_ready", s_axis_tready, 1);
        send(5, 4'hF, 0, 0);
        chk("two_held_ready", s_axis_tready, 0);
        repeat (5) tick();
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_data", m_axis_tdata, 4);
        chk("stall_ready", s_axis_tready, 0);
        m_axis_tready = 1'b1;
        send(6, 4'hF, 0, 0);
        send(7, 4'hF, 1, 0);
        repeat (3) tick();
        chk_counts("stall", 15, 47, 2, 4'b1011);

        // Error and clear in the same cycle, then reset mid-packet.
        packet_size = 32'd4;
        send(0, 4'hF, 0, 0);
        send(7, 4'hF, 0, 1);
        chk("clr_errs", err_count, 1);
        chk("clr_flags", err_flags, 4'b0001);
        chk("clr_err_exp", err_exp, CAP_EN ? 32'd1 : 32'd0);
        chk("clr_err_got", err_got, CAP_EN ? 32'd7 : 32'd0);
        m_axis_tready = 1'b0;
        send(2, 4'hF, 0, 0);
        areset = 1'b1;
        tick();
        sb.delete();
        chk("mid_rst_s_ready", s_axis_tready, 0);
        chk("mid_rst_m_out", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
        chk_counts("mid_rst", 0, 0, 0, 4'b0000);
        chk("mid_rst_err_exp", err_exp, 0);
        chk("mid_rst_err_got", err_got, 0);
        areset = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        chk("mid_rst_ready_back", s_axis_tready, 1);
        send(0, 4'hF, 0, 0);
        packet_size = 32'd2;
        send(1, 4'hF, 0, 0);
        send(2, 4'hF, 0, 0);
        send(3, 4'hF, 1, 0);
        repeat (3) tick();
        chk_counts("after_rst", 1, 4, 0, 4'b0000);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_seq_checker.md
Name: axis_seq_checker

Overview:
- In-line AXI4-Stream monitor directly downstream of the 32-bit up-counter source, ahead of the DMA S2MM input.
- Passes every beat through unchanged via a 2-entry skid buffer.
- Checks that each packet carries the sequence 0,1,...,N-1 with TLAST on word N-1 and all bytes kept.
- Exposes packet, word and error counters plus sticky error flags for software or ILA.

Parameters:
- DATA_W, 32, stream data width; tkeep width is DATA_W/8.
- CNT_W, 32, width of pkt_count, word_count and err_count.

Ports:
- aclk  in  1  clock; one clock domain: reset is synchronous and active-high.
- areset  in  1  reset, synchronous, active-high.
- packet_size  in  32  expected words per packet; sampled on the first beat of each packet.
- err_clear  in  1  one-cycle pulse; clears err_count, err_flags and the first-error capture.
- s_axis_tdata  in  DATA_W  input data.
- s_axis_tkeep  in  DATA_W/8  input byte enables.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_W  forwarded data.
- m_axis_tkeep  out  DATA_W/8  forwarded byte enables.
- m_axis_tlast  out  1  forwarded end of packet.
- m_axis_tvalid  out  1  forwarded valid.
- m_axis_tready  in  1  downstream ready.
- pkt_count  out  CNT_W  packets completed, i.e. accepted beats with tlast=1.
- word_count  out  CNT_W  total accepted beats.
- err_count  out  CNT_W  beats carrying at least one error.
- err_flags  out  4  sticky error flags: [0] data mismatch, [1] early tlast, [2] late/missing tlast, [3] tkeep not all ones.
- err_exp  out  32  expected index at the first error.
- err_got  out  32  received tdata at the first error.

Behaviour:
- Reset (synchronous, areset=1 at a clock edge):
  - Buffer emptied; m_axis_tvalid=0; s_axis_tready=0 during reset and 1 on the first cycle after it.
  - All counters, flags, err_exp, err_got and m_axis_* data fields = 0.
  - Checker returns to IDLE.
  - Reset mid-packet discards buffered beats; the next accepted beat is treated as a packet start.
- Skid buffer:
  - Holds 2 entries.
  - s_axis_tready is registered and equals "fewer than 2 entries occupied after this cycle's transfers".
  - Latency from input handshake to m_axis_tvalid = 1 cycle.
  - Beats are never dropped, duplicated or reordered.
  - m_axis_* fields stay stable while m_axis_tvalid=1 and m_axis_tready=0.
  - Simultaneous input accept and output pop with 1 entry held: occupancy stays at 1.
  - Full throughput of 1 beat/cycle is sustained when m_axis_tready stays high.
- Checking happens on the input handshake only (s_axis_tvalid && s_axis_tready).
- Checker state machine, with internal index idx (32 b) and latched size sz:
  - IDLE:
    - On a beat: sz = packet_size, where 0 is treated as 1.
    - Check the beat as idx=0.
    - tlast=1 completes the packet: stay in IDLE.
    - Otherwise go to IN_PKT with idx=1.
  - IN_PKT, on a beat:
    - tdata != idx sets flag[0].
    - tlast=1 and idx < sz-1 sets flag[1], completes the packet, goes to IDLE.
    - idx == sz-1 and tlast=0 sets flag[2] and goes to OVERRUN.
    - Otherwise idx increments.
  - OVERRUN: beats are not data-checked; only flag[3] is checked. On tlast=1, go to IDLE and count the packet.
  - In all states, tkeep != all-ones sets flag[3].
  - The expected sequence follows idx, not the received tdata: one corrupt word yields exactly one mismatch.
- Counters:
  - word_count increments on every accepted beat; pkt_count increments on every accepted tlast.
  - err_count increments at most once per beat, whatever the number of error kinds.
  - All counters saturate at all-ones and do not wrap.
- err_clear:
  - Zeroes err_count, err_flags, err_exp and err_got.
  - If an error beat occurs in the same cycle, the new error wins: err_count=1, its flags are set, and it is captured.
  - err_clear does not touch pkt_count, word_count or the state machine.
- packet_size changes mid-packet have no effect until the next packet start.

Optional Feature:
- Macro: AXIS_SEQ_CHECKER_FIRST_ERR_EN.
- Defined: err_exp and err_got load idx and tdata on the first error beat after reset or err_clear, then hold until the next reset or err_clear. For OVERRUN/tkeep-only errors, err_exp is loaded with idx.
- Undefined: the capture logic is removed and err_exp and err_got are constant 0.

Test Plan:
- packet_size=4, clean source, m_axis_tready=1, 3 packets -> output beats identical to input at 1-cycle latency; pkt_count=3, word_count=12, err_count=0, err_flags=0.
- packet_size=1, 5 single-beat packets (tdata=0, tlast=1) -> pkt_count=5, no errors.
- packet_size=4, word 2 corrupted to 0x55 -> err_count=1, flags=0001, err_exp=2, err_got=0x55 (macro on); next packet clean.
- packet_size=4, tlast on word 1; then a packet with no tlast until word 5 -> flags=0110; err_count=2; pkt_count=2; state returns to IDLE.
- m_axis_tready toggling 1010... plus a 5-cycle stall mid-packet -> s_axis_tready drops after 2 held beats; no loss or reorder; output stable while stalled.
- Error and err_clear in the same cycle, then areset asserted mid-packet -> err_count=1 after the clear; after reset all outputs=0 and the next beat (tdata=0) starts a clean packet.
